countdown_timer: RTL
====================

Name: countdown_timer

Overview:
- Consumes the slow square wave from the frequency divider (its `clock_1` output). It runs a BCD minutes:seconds countdown in the main 25 MHz `clock` domain.
- Provides load, start and pause control, plus done and alarm indications.
- Downstream stages (display multiplexer, buzzer driver) read its BCD digits and status outputs.

Parameters:
- MAX_MIN, 8'h99, largest accepted BCD minutes value on load.
- TICK_RST, 1'b1, reset value of the tick-edge register; 1 suppresses a spurious tick when `tick_in` is already high at reset release.

Ports:
- clock  in  1  system clock, 25 MHz
- reset  in  1  synchronous, active-low reset
- tick_in  in  1  divider output, level signal; each rising edge is one second
- load  in  1  one-cycle pulse; captures load_min/load_sec
- start  in  1  one-cycle pulse; start/resume/acknowledge
- pause  in  1  one-cycle pulse; pause while running
- load_min  in  8  BCD minutes {tens,ones}
- load_sec  in  8  BCD seconds {tens,ones}
- min_bcd  out  8  current BCD minutes
- sec_bcd  out  8  current BCD seconds
- running  out  1  high in RUN
- done  out  1  one-cycle pulse on reaching 00:00
- alarm  out  1  level, high in DONE

Behaviour:
- All state changes on posedge clock. Only `clock` clocks any flop; `tick_in` is a data input.
- Reset (reset==0 at posedge):
  - state=IDLE, min_bcd=8'h00, sec_bcd=8'h00, running=0, done=0, alarm=0, tick_d=TICK_RST.
  - Reset mid-count aborts immediately with no done pulse.
- Tick detect:
  - tick_d<=tick_in every cycle; tick_rise = tick_in & ~tick_d.
  - Decrement takes effect on the clock edge where tick_rise=1, so the new value is visible one cycle after tick_in rises.
- Load validity: load is valid iff every nibble <=9, sec tens <=5, and load_min<=MAX_MIN. An invalid load is ignored entirely: no state or value change.
- States:
  - IDLE: value held. Valid load -> capture, stay IDLE. start with value !=00:00 -> RUN. start with 00:00 -> stay IDLE.
  - RUN:
    - tick_rise decrements by one second.
    - Decrement from 00:01 -> value 00:00, state DONE, done=1 for exactly that cycle.
    - pause -> PAUSED.
    - Valid load -> capture, IDLE (abort, no done).
  - PAUSED: ticks ignored; value frozen. start -> RUN. Valid load -> capture, IDLE.
  - DONE: alarm=1, value 00:00, ticks ignored. start -> IDLE, alarm=0. Valid load -> capture, IDLE, alarm=0.
- Decrement arithmetic:
  - sec ones 0 -> 9 with borrow into sec tens, else ones-1.
  - sec tens 0 with borrow -> 5 with borrow into minutes.
  - Minutes follow the same BCD rule: ones 0 -> 9 with borrow into tens.
  - 00:00 is never decremented.
  - Examples: 10:00 -> 09:59; 01:00 -> 00:59.
- Simultaneous events, priority highest first:
  1. Valid load beats everything.
  2. In RUN, tick_rise and pause in the same cycle: decrement applies, then state PAUSED. If that decrement reaches 00:00, DONE wins over pause.
  3. In PAUSED, start and pause together: start wins.
  4. In RUN, a start pulse is ignored.
- running is registered and equals (state==RUN). No combinational path from any input to any output.

Test Plan:
- Reset release with tick_in=1: min/sec=00:00, running=0, alarm=0; no decrement on the first cycle, and none until tick_in falls and rises again.
- load 01:05, start, 65 tick_in rising edges:
  - After 5 ticks the value is 01:00; after 6 it is 00:59.
  - After 65 ticks the value is 00:00, done is high for exactly one cycle, alarm=1, running=0.
- load 00:10, start, 3 ticks, pause, 4 ticks, start, 7 ticks:
  - The value is 00:07 while paused, and the 4 paused ticks do not change it.
  - After the final 7 ticks: value 00:00 and done pulses.
- Invalid loads: load_sec=8'h60, then load_min=8'h1A, each in IDLE -> value and state unchanged. Then a valid load 10:00 and start; one tick -> 09:59.
- Same-cycle events:
  - At 00:01 in RUN, tick_rise and pause in the same cycle -> 00:00, DONE, done=1.
  - Separately, load 00:30 in the same cycle as tick_rise while RUN -> 00:30, IDLE, no decrement.
- reset driven low mid-count at 00:42 for one cycle -> 00:00 IDLE, done never pulses. Then start with 00:00 -> remains IDLE.

Source files
------------

// File: rtl/countdown_timer.sv
// BCD mm:ss countdown driven by rising edges of a slow divider output.
// Load/start/pause control with a one-cycle done pulse and a level alarm.
module countdown_timer #(
   parameter logic [7:0] MAX_MIN  = 8'h99,
   parameter logic       TICK_RST = 1'b1
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       tick_in,
   input  logic       load,
   input  logic       start,
   input  logic       pause,
   input  logic [7:0] load_min,
   input  logic [7:0] load_sec,
   output logic [7:0] min_bcd,
   output logic [7:0] sec_bcd,
   output logic       running,
   output logic       done,
   output logic       alarm
);

   typedef enum logic [1:0] {IDLE, RUN, PAUSED, DONE} state_t;

   state_t      state_q, state_d;
   logic [15:0] val_q, val_d;
   logic        tick_q;
   logic        done_q;
   logic        tick_rise, load_ok, val_zero;
   logic [15:0] val_dec;

   // One-second BCD decrement; caller guarantees the value is non-zero.
   function automatic logic [15:0] dec_bcd(input logic [15:0] v);
      logic [15:0] r;
      r = v;
      if (v[3:0] != 4'd0) r[3:0] = v[3:0] - 4'd1;
      else begin
         r[3:0] = 4'd9;
         if (v[7:4] != 4'd0) r[7:4] = v[7:4] - 4'd1;
         else begin
            r[7:4] = 4'd5;
            if (v[11:8] != 4'd0) r[11:8] = v[11:8] - 4'd1;
            else begin
               r[11:8]  = 4'd9;
               r[15:12] = v[15:12] - 4'd1;
            end
         end
      end
      return r;
   endfunction

   assign tick_rise = tick_in & ~tick_q;
   assign val_zero  = (val_q == 16'h0000);
   assign val_dec   = dec_bcd(val_q);
   assign load_ok   = (load_min[7:4] <= 4'd9) && (load_min[3:0] <= 4'd9) &&
                      (load_sec[7:4] <= 4'd5) && (load_sec[3:0] <= 4'd9) &&
                      (load_min <= MAX_MIN);

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q <= IDLE;
         val_q   <= 16'h0000;
         tick_q  <= TICK_RST;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         val_q   <= val_d;
         tick_q  <= tick_in;
         done_q  <= (state_q == RUN) && (state_d == DONE);
      end
   end

   always_comb begin
      state_d = state_q;
      val_d   = val_q;
      if (load && load_ok) begin
         val_d   = {load_min, load_sec};
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE:    if (start && !val_zero) state_d = RUN;
            RUN: begin
               // A tick reaching zero beats a same-cycle pause.
               if (tick_rise) begin
                  val_d = val_dec;
                  if (val_dec == 16'h0000) state_d = DONE;
                  else if (pause)          state_d = PAUSED;
               end else if (pause) state_d = PAUSED;
            end
            PAUSED:  if (start) state_d = RUN;
            DONE:    if (start) state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   always_comb begin
      min_bcd = val_q[15:8];
      sec_bcd = val_q[7:0];
      running = (state_q == RUN);
      alarm   = (state_q == DONE);
      done    = done_q;
   end

endmodule
